// File: rtl/match_judge_pkg.sv
// Shared types for the match judge: FSM states, card position and symbol width.
package match_judge_pkg;

  localparam int unsigned SymW   = 3;
  localparam int unsigned CoordW = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFirst,
    StCompare,
    StShow,
    StHide,
    StOver
  } judge_state_e;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } card_pos_t;

endpackage

// File: rtl/match_judge_hold_timer.sv
// Down-counter holding mismatched cards face-up; done_o is high while the count is zero.
module match_judge_hold_timer #(
  parameter int unsigned HoldCycles = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  // At least one bit so that HoldCycles == 1 still builds.
  localparam int unsigned CntW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(HoldCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/match_judge.sv
// Pairs consecutive card reveals, credits matches and schedules hiding of mismatches.
module match_judge
  import match_judge_pkg::*;
#(
  parameter int unsigned HoldCycles = 50_000_000,
  parameter int unsigned NumPairs   = 8,
  parameter int unsigned ScoreW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              selection_i,
  input  logic [3:0]        card_val_i,
  input  logic [1:0]        card_x_i,
  input  logic [1:0]        card_y_i,
  output logic              busy_o,
  output logic              hide_req_o,
  output logic [1:0]        hide_x1_o,
  output logic [1:0]        hide_y1_o,
  output logic [1:0]        hide_x2_o,
  output logic [1:0]        hide_y2_o,
  output logic              match_o,
  output logic              player_o,
  output logic [ScoreW-1:0] score0_o,
  output logic [ScoreW-1:0] score1_o,
  output logic              game_over_o
);

  localparam int unsigned PairsW = $clog2(NumPairs + 1);

  judge_state_e    state_d, state_q;
  card_pos_t       first_d, first_q, second_d, second_q;
  card_pos_t       hide1_d, hide1_q, hide2_d, hide2_q;
  logic [SymW-1:0] sym1_d, sym1_q, sym2_d, sym2_q;
  logic            match_d, match_q;
  logic            player_d, player_q;
  logic [ScoreW-1:0] score_d [2];
  logic [ScoreW-1:0] score_q [2];
  logic [PairsW-1:0] pairs_d, pairs_q;
  logic            timer_load, timer_done;

  // The face-up flag is informational only; matching uses the symbol bits.
  logic unused_face_up;
  assign unused_face_up = card_val_i[3];

  match_judge_hold_timer #(
    .HoldCycles(HoldCycles)
  ) u_hold_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i(timer_load),
    .en_i  (state_q == StShow),
    .done_o(timer_done)
  );

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    second_d   = second_q;
    hide1_d    = hide1_q;
    hide2_d    = hide2_q;
    sym1_d     = sym1_q;
    sym2_d     = sym2_q;
    match_d    = 1'b0;
    player_d   = player_q;
    score_d    = score_q;
    pairs_d    = pairs_q;
    timer_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (selection_i) begin
          first_d.x = card_x_i;
          first_d.y = card_y_i;
          sym1_d    = card_val_i[SymW-1:0];
          state_d   = StFirst;
        end
      end
      StFirst: begin
        if (selection_i && ((card_x_i != first_q.x) || (card_y_i != first_q.y))) begin
          second_d.x = card_x_i;
          second_d.y = card_y_i;
          sym2_d     = card_val_i[SymW-1:0];
          state_d    = StCompare;
        end
      end
      StCompare: begin
        if (sym1_q == sym2_q) begin
          match_d = 1'b1;
          if (score_q[player_q] != '1) begin
            score_d[player_q] = score_q[player_q] + ScoreW'(1);
          end
          pairs_d = pairs_q + PairsW'(1);
          state_d = (pairs_d == PairsW'(NumPairs)) ? StOver : StIdle;
        end else begin
          timer_load = 1'b1;
          hide1_d    = first_q;
          hide2_d    = second_q;
          state_d    = StShow;
        end
      end
      StShow: begin
        if (timer_done) begin
          state_d = StHide;
        end
      end
      StHide: begin
        player_d = ~player_q;
        state_d  = StIdle;
      end
      StOver: begin
        state_d = StOver;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      first_q  <= '0;
      second_q <= '0;
      hide1_q  <= '0;
      hide2_q  <= '0;
      sym1_q   <= '0;
      sym2_q   <= '0;
      match_q  <= 1'b0;
      player_q <= 1'b0;
      score_q  <= '{default: '0};
      pairs_q  <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      second_q <= second_d;
      hide1_q  <= hide1_d;
      hide2_q  <= hide2_d;
      sym1_q   <= sym1_d;
      sym2_q   <= sym2_d;
      match_q  <= match_d;
      player_q <= player_d;
      score_q  <= score_d;
      pairs_q  <= pairs_d;
    end
  end

  assign busy_o      = (state_q == StCompare) || (state_q == StShow) ||
                       (state_q == StHide) || (state_q == StOver);
  assign hide_req_o  = (state_q == StHide);
  assign game_over_o = (state_q == StOver);
  assign hide_x1_o   = hide1_q.x;
  assign hide_y1_o   = hide1_q.y;
  assign hide_x2_o   = hide2_q.x;
  assign hide_y2_o   = hide2_q.y;
  assign match_o     = match_q;
  assign player_o    = player_q;
  assign score0_o    = score_q[0];
  assign score1_o    = score_q[1];

endmodule
